// File: rtl/watch_if.sv
// watch_if: control inputs and display/status outputs of the multi-alarm watch core.
interface watch_if #(
    parameter int NUM_ALARMS = 2,
    parameter int AW = NUM_ALARMS > 1 ? $clog2(NUM_ALARMS) : 1
);
    logic                  en;
    logic                  mode_btn;
    logic                  sel_btn;
    logic                  inc_btn;
    logic                  snooze;
    logic [AW-1:0]         alm_sel;
    logic [NUM_ALARMS-1:0] alm_en;
    logic [3:0]            disp_hour;
    logic [5:0]            disp_min;
    logic [5:0]            disp_sec;
    logic                  disp_pm;
    logic [1:0]            mode;
    logic [1:0]            field;
    logic                  ring;
    logic [AW-1:0]         ring_id;
    logic                  sec_tick;
    logic                  blink;

    modport master (
        output en, mode_btn, sel_btn, inc_btn, snooze, alm_sel, alm_en,
        input  disp_hour, disp_min, disp_sec, disp_pm, mode, field, ring, ring_id, sec_tick, blink
    );
    modport slave (
        input  en, mode_btn, sel_btn, inc_btn, snooze, alm_sel, alm_en,
        output disp_hour, disp_min, disp_sec, disp_pm, mode, field, ring, ring_id, sec_tick, blink
    );
endinterface

// File: rtl/watch_multi_alarm.sv
// watch_multi_alarm: 12-hour watch with NUM_ALARMS alarms, time/alarm set modes and timed ringing.
// Optional snooze countdown is built only when WATCH_SNOOZE_EN is defined.
module watch_multi_alarm #(
    parameter int TICK_DIV   = 10000,
    parameter int NUM_ALARMS = 2,
    parameter int RING_SECS  = 60,
    parameter int SNOOZE_MIN = 5
) (
    input logic clk,
    input logic rst,
    watch_if.slave bus
);
    localparam int AW = NUM_ALARMS > 1 ? $clog2(NUM_ALARMS) : 1;
    localparam int PW = $clog2(TICK_DIV);
    localparam int EW = 1 << AW;
    localparam logic [7:0] RING_LOAD = 8'(RING_SECS);

    typedef enum logic [1:0] {SHOW = 2'd0, ASET = 2'd1, TSET = 2'd2, BAD = 2'd3} mode_t;
    typedef enum logic [1:0] {F_MIN = 2'd0, F_HOUR = 2'd1, F_PM = 2'd2, F_BAD = 2'd3} field_t;

    function automatic logic [5:0] inc_min(input logic [5:0] m);
        return m == 6'd59 ? 6'd0 : m + 6'd1;
    endfunction

    function automatic logic [3:0] inc_hour(input logic [3:0] h);
        return h == 4'd12 ? 4'd1 : h + 4'd1;
    endfunction

    logic [PW-1:0] pc;
    logic [5:0]    sec, sec_n, min, min_n;
    logic [3:0]    hour, hour_n;
    logic          pm, pm_n;
    logic [5:0]    a_min [NUM_ALARMS];
    logic [5:0]    a_min_n [NUM_ALARMS];
    logic [3:0]    a_hour [NUM_ALARMS];
    logic [3:0]    a_hour_n [NUM_ALARMS];
    logic          a_pm [NUM_ALARMS];
    logic          a_pm_n [NUM_ALARMS];
    mode_t         mode_q, mode_n;
    field_t        field_q, field_n;
    logic          ring, ring_n;
    logic [AW-1:0] rid, rid_n, hid, sel_idx;
    logic [7:0]    rcnt, rcnt_n;
    logic          hit, st;
    logic [3:0]    d_hour, d_hour_n;
    logic [5:0]    d_min, d_min_n, d_sec, d_sec_n;
    logic          d_pm, d_pm_n;
    logic [EW-1:0] en_pad;
    logic          tick, run, mode_chg, dismiss, edit;

`ifdef WATCH_SNOOZE_EN
    logic          snz, snz_n;
    logic [AW-1:0] sid, sid_n;
    logic [11:0]   scnt, scnt_n;
`else
    localparam int unused_snooze_min = SNOOZE_MIN;
    logic unused_snooze;
    assign unused_snooze = bus.snooze;
`endif

    assign tick     = bus.en && pc == PW'(TICK_DIV - 1);
    assign run      = tick && mode_q != TSET;
    assign mode_chg = bus.mode_btn && !ring;
    assign dismiss  = bus.mode_btn && ring;
    assign edit     = bus.inc_btn && !bus.mode_btn;
    assign sel_idx  = {1'b0, bus.alm_sel} < (AW + 1)'(NUM_ALARMS) ? bus.alm_sel : '0;
    assign en_pad   = EW'(bus.alm_en);

    always_comb begin
        mode_n = mode_q;
        if (mode_q == BAD)
            mode_n = SHOW;
        else if (mode_chg)
            mode_n = mode_q == SHOW ? ASET : mode_q == ASET ? TSET : SHOW;
        field_n = field_q;
        if (mode_n != mode_q)
            field_n = F_MIN;
        else if (bus.sel_btn && !bus.mode_btn && mode_q != SHOW)
            field_n = field_q == F_MIN ? F_HOUR : field_q == F_HOUR ? F_PM : F_MIN;
    end

    always_comb begin
        sec_n  = sec;
        min_n  = min;
        hour_n = hour;
        pm_n   = pm;
        if (run) begin
            sec_n = sec == 6'd59 ? 6'd0 : sec + 6'd1;
            if (sec == 6'd59) begin
                min_n = inc_min(min);
                if (min == 6'd59) begin
                    hour_n = inc_hour(hour);
                    pm_n   = hour == 4'd11 ? !pm : pm;
                end
            end
        end else if (edit && mode_q == TSET) begin
            sec_n  = '0;
            min_n  = field_q == F_MIN ? inc_min(min) : min;
            hour_n = field_q == F_HOUR ? inc_hour(hour) : hour;
            pm_n   = pm ^ (field_q == F_PM);
        end
    end

    always_comb begin
        a_min_n  = a_min;
        a_hour_n = a_hour;
        a_pm_n   = a_pm;
        if (edit && mode_q == ASET) begin
            a_min_n[sel_idx]  = field_q == F_MIN ? inc_min(a_min[sel_idx]) : a_min[sel_idx];
            a_hour_n[sel_idx] = field_q == F_HOUR ? inc_hour(a_hour[sel_idx]) : a_hour[sel_idx];
            a_pm_n[sel_idx]   = a_pm[sel_idx] ^ (field_q == F_PM);
        end
    end

    // Descending scan so the lowest matching alarm index is the one left in hid.
    always_comb begin
        hit = 1'b0;
        hid = '0;
        for (int k = NUM_ALARMS - 1; k >= 0; k--)
            if (bus.alm_en[k] && a_hour[k] == hour_n && a_min[k] == min_n && a_pm[k] == pm_n) begin
                hit = 1'b1;
                hid = AW'(k);
            end
        hit = hit && run && sec_n == 6'd0;
    end

    always_comb begin
        ring_n = ring;
        rid_n  = rid;
        rcnt_n = rcnt;
        if (tick && ring) begin
            rcnt_n = rcnt - 8'd1;
            ring_n = rcnt_n != 8'd0;
        end
        if (dismiss || !en_pad[rid])
            ring_n = 1'b0;
`ifdef WATCH_SNOOZE_EN
        snz_n  = snz;
        sid_n  = sid;
        scnt_n = scnt;
        if (bus.snooze && ring) begin
            ring_n = 1'b0;
            snz_n  = 1'b1;
            sid_n  = rid;
            scnt_n = 12'(SNOOZE_MIN * 60);
        end else if (run && snz) begin
            scnt_n = scnt - 12'd1;
            if (scnt_n == 12'd0) begin
                snz_n = 1'b0;
                if (en_pad[sid]) begin
                    ring_n = 1'b1;
                    rid_n  = sid;
                    rcnt_n = RING_LOAD;
                end
            end
        end
        if (dismiss || hit)
            snz_n = 1'b0;
`endif
        if (hit) begin
            ring_n = 1'b1;
            rid_n  = hid;
            rcnt_n = RING_LOAD;
        end
    end

    // Display is registered from next-state values so it lines up with mode, ring and sec_tick.
    always_comb begin
        d_hour_n = mode_n == ASET ? a_hour_n[sel_idx] : hour_n;
        d_min_n  = mode_n == ASET ? a_min_n[sel_idx] : min_n;
        d_sec_n  = mode_n == ASET ? 6'd0 : sec_n;
        d_pm_n   = mode_n == ASET ? a_pm_n[sel_idx] : pm_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= SHOW;
            field_q <= F_MIN;
        end else begin
            mode_q  <= mode_n;
            field_q <= field_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc     <= '0;
            sec    <= '0;
            min    <= '0;
            hour   <= 4'd12;
            pm     <= 1'b0;
            a_min  <= '{default: 6'd0};
            a_hour <= '{default: 4'd12};
            a_pm   <= '{default: 1'b0};
            ring   <= 1'b0;
            rid    <= '0;
            rcnt   <= '0;
            st     <= 1'b0;
            d_hour <= 4'd12;
            d_min  <= '0;
            d_sec  <= '0;
            d_pm   <= 1'b0;
`ifdef WATCH_SNOOZE_EN
            snz    <= 1'b0;
            sid    <= '0;
            scnt   <= '0;
`endif
        end else begin
            if (bus.en)
                pc <= tick ? '0 : pc + PW'(1);
            sec    <= sec_n;
            min    <= min_n;
            hour   <= hour_n;
            pm     <= pm_n;
            a_min  <= a_min_n;
            a_hour <= a_hour_n;
            a_pm   <= a_pm_n;
            ring   <= ring_n;
            rid    <= rid_n;
            rcnt   <= rcnt_n;
            st     <= tick;
            d_hour <= d_hour_n;
            d_min  <= d_min_n;
            d_sec  <= d_sec_n;
            d_pm   <= d_pm_n;
`ifdef WATCH_SNOOZE_EN
            snz    <= snz_n;
            sid    <= sid_n;
            scnt   <= scnt_n;
`endif
        end
    end

    assign bus.disp_hour = d_hour;
    assign bus.disp_min  = d_min;
    assign bus.disp_sec  = d_sec;
    assign bus.disp_pm   = d_pm;
    assign bus.mode      = mode_q;
    assign bus.field     = field_q;
    assign bus.ring      = ring;
    assign bus.ring_id   = rid;
    assign bus.sec_tick  = st;
    assign bus.blink     = sec[0];
endmodule
